// File: rtl/ysyx_210544_cache_line_xfer.sv
// Cache-line transfer engine: moves one cache line between a cache and an AXI-style
// request/ready port, either as one burst or, for the narrow address region, as a
// sequence of single narrow beats.
//
// Optional feature macro: CACHE_LINE_XFER_NARROW_EN
//   defined   -> addresses with addr[31:28] == NARROW_TAG use LINE_BYTES/NARROW_BYTES
//                single transfers (NARROW state)
//   undefined -> every address takes the burst path; no NARROW state or beat counter
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_cache_axi_req/addr/op   level request from the cache, byte address, 0 read / 1 write
//   i_cache_axi_wdata         line to write
//   o_cache_axi_rdata         line read back
//   o_cache_axi_ack/err       one-cycle completion pulse, error flag (held until next request)
//   o_axi_io_*/i_axi_io_*     downstream request: valid/ready handshake, op, addr, size
//                             (log2 bytes per beat), blks (beats - 1), wdata/rdata, resp
module ysyx_210544_cache_line_xfer #(
  parameter int unsigned LINE_BYTES   = 64,
  parameter int unsigned BEAT_BYTES   = 8,
  parameter int unsigned NARROW_BYTES = 4,
  parameter logic [3:0]  NARROW_TAG   = 4'h3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cache_axi_req,
  input  logic [63:0]             i_cache_axi_addr,
  input  logic                    i_cache_axi_op,
  input  logic [LINE_BYTES*8-1:0] i_cache_axi_wdata,
  output logic [LINE_BYTES*8-1:0] o_cache_axi_rdata,
  output logic                    o_cache_axi_ack,
  output logic                    o_cache_axi_err,
  output logic                    o_axi_io_op,
  output logic                    o_axi_io_valid,
  input  logic                    i_axi_io_ready,
  input  logic [1:0]              i_axi_io_resp,
  output logic [63:0]             o_axi_io_addr,
  output logic [LINE_BYTES*8-1:0] o_axi_io_wdata,
  input  logic [LINE_BYTES*8-1:0] i_axi_io_rdata,
  output logic [1:0]              o_axi_io_size,
  output logic [7:0]              o_axi_io_blks
);

  localparam int unsigned LineW = LINE_BYTES * 8;
  localparam int unsigned OffW  = $clog2(LINE_BYTES);

`ifdef CACHE_LINE_XFER_NARROW_EN
  localparam int unsigned NarrowW = NARROW_BYTES * 8;
  localparam int unsigned NBeats  = LINE_BYTES / NARROW_BYTES;
  localparam int unsigned CntW    = $clog2(NBeats);

  typedef enum logic [1:0] {StIdle, StBurst, StNarrow, StDone} state_e;

  logic            narrow_q, narrow_d;
  logic [CntW-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;
`endif

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic              valid_q, valid_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [63:0]       addr_q, addr_d;
  logic [LineW-1:0]  line_q, line_d;
  logic [LineW-1:0]  rdata_q, rdata_d;

  logic hs;
  logic resp_ok;
  assign hs      = valid_q & i_axi_io_ready;
  assign resp_ok = (i_axi_io_resp == 2'b00);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    valid_d = valid_q;
    ack_d   = 1'b0;
    err_d   = err_q;
    addr_d  = addr_q;
    line_d  = line_q;
    rdata_d = rdata_q;
`ifdef CACHE_LINE_XFER_NARROW_EN
    narrow_d = narrow_q;
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_cache_axi_req) begin
          op_d    = i_cache_axi_op;
          line_d  = i_cache_axi_wdata;
          addr_d  = {i_cache_axi_addr[63:OffW], {OffW{1'b0}}};
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = StBurst;
`ifdef CACHE_LINE_XFER_NARROW_EN
          narrow_d = (i_cache_axi_addr[31:28] == NARROW_TAG);
          cnt_d    = '0;
          if (i_cache_axi_addr[31:28] == NARROW_TAG) state_d = StNarrow;
`endif
        end
      end
      StBurst: begin
        if (hs) begin
          // An erroring response carries no usable data, so rdata is left alone.
          if (!op_q && resp_ok) rdata_d = i_axi_io_rdata;
          err_d   = !resp_ok;
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = StDone;
        end
      end
`ifdef CACHE_LINE_XFER_NARROW_EN
      StNarrow: begin
        if (hs) begin
          if (!resp_ok) begin
            err_d   = 1'b1;
            valid_d = 1'b0;
            ack_d   = 1'b1;
            state_d = StDone;
          end else begin
            if (!op_q) rdata_d[cnt_q*NarrowW +: NarrowW] = i_axi_io_rdata[NarrowW-1:0];
            if (cnt_q == CntW'(NBeats - 1)) begin
              valid_d = 1'b0;
              ack_d   = 1'b1;
              state_d = StDone;
            end else begin
              // valid stays high so the next beat follows with no idle cycle
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
`endif
      StDone: begin
        // Wait for req to drop so a held request never starts a second transfer.
        if (!i_cache_axi_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 1'b0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
`ifdef CACHE_LINE_XFER_NARROW_EN
      narrow_q <= 1'b0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
`ifdef CACHE_LINE_XFER_NARROW_EN
      narrow_q <= narrow_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign o_cache_axi_rdata = rdata_q;
  assign o_cache_axi_ack   = ack_q;
  assign o_cache_axi_err   = err_q;
  assign o_axi_io_op       = op_q;
  assign o_axi_io_valid    = valid_q;

`ifdef CACHE_LINE_XFER_NARROW_EN
  always_comb begin
    if (narrow_q) begin
      o_axi_io_addr  = addr_q + 64'(cnt_q) * 64'(NARROW_BYTES);
      o_axi_io_wdata = LineW'(line_q[cnt_q*NarrowW +: NarrowW]);
      o_axi_io_size  = 2'($clog2(NARROW_BYTES));
      o_axi_io_blks  = 8'd0;
    end else begin
      o_axi_io_addr  = addr_q;
      o_axi_io_wdata = line_q;
      o_axi_io_size  = 2'($clog2(BEAT_BYTES));
      o_axi_io_blks  = 8'(LINE_BYTES / BEAT_BYTES - 1);
    end
  end

  logic unused_ok;
  assign unused_ok = ^i_cache_axi_addr[OffW-1:0];
`else
  assign o_axi_io_addr  = addr_q;
  assign o_axi_io_wdata = line_q;
  assign o_axi_io_size  = 2'($clog2(BEAT_BYTES));
  assign o_axi_io_blks  = 8'(LINE_BYTES / BEAT_BYTES - 1);

  logic unused_ok;
  assign unused_ok = ^{i_cache_axi_addr[OffW-1:0], NARROW_TAG, NARROW_BYTES[0]};
`endif

endmodule
